// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared constants and types for the AES-128 round scheduler
package aes_pkg;

  localparam int NUM_CTX           = 4;
  localparam int NUM_ROUNDS_AES128 = 10;

  typedef enum logic [1:0] {
    CTX_IDLE     = 2'd0,
    CTX_READY    = 2'd1,
    CTX_INFLIGHT = 2'd2,
    CTX_DONE     = 2'd3
  } ctx_state_t;

  // Debug readback word layout
  localparam int DBG_RDCNT_LSB = 0;
  localparam int DBG_LGNT_LSB  = 8;
  localparam int DBG_ERR_LSB   = 12;
  localparam int DBG_ISSUE_LSB = 16;

endpackage

// File: rtl/rr_arb4.sv
// rtl/rr_arb4.sv - 4-way round-robin arbiter, combinational; search begins one past last_i
module rr_arb4 (
  input  logic [3:0] req_i,
  input  logic [1:0] last_i,
  output logic [3:0] gnt_o,
  output logic [1:0] gnt_idx_o,
  output logic       gnt_vld_o
);

  logic [1:0] cand;

  always_comb begin
    gnt_o     = '0;
    gnt_idx_o = '0;
    gnt_vld_o = 1'b0;
    cand      = '0;
    for (int k = 1; k <= 4; k++) begin
      cand = last_i + 2'(k);
      if (!gnt_vld_o && req_i[cand]) begin
        gnt_vld_o   = 1'b1;
        gnt_idx_o   = cand;
        gnt_o[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/aes_round_sched.sv
// rtl/aes_round_sched.sv - round scheduler for four AES-128 contexts sharing one round datapath
// AES_SCHED_DEBUG_EN builds the CPU debug readback register; otherwise cpu_rd_data is 0.
module aes_round_sched
  import aes_pkg::*;
#(
  parameter int NUM_ROUNDS     = NUM_ROUNDS_AES128,
  parameter int PIPE_LAT       = 4,
  parameter int CPU_DATA_WIDTH = 32
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [3:0]                slot_start,
  input  logic [3:0]                slot_ack,
  output logic [3:0]                slot_busy,
  output logic [3:0]                slot_done,
  output logic                      dp_issue_vld,
  output logic [1:0]                dp_pntr_num,
  output logic [3:0]                dp_round,
  output logic                      dp_final_round,
  input  logic                      dp_ret_vld,
  input  logic [1:0]                dp_ret_pntr,
  input  logic                      cpu_rd,
  output logic [CPU_DATA_WIDTH-1:0] cpu_rd_data,
  output logic                      err_sticky
);

  localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS);
  // Datapath latency is documentation only; scheduling is driven purely by returns.
  localparam int unused_pipe_lat = PIPE_LAT;

  ctx_state_t st_q    [NUM_CTX];
  ctx_state_t st_d    [NUM_CTX];
  logic [3:0] round_q [NUM_CTX];
  logic [3:0] round_d [NUM_CTX];
  logic [1:0] last_grant_q;
  logic       issue_vld_q;
  logic [1:0] issue_pntr_q;
  logic [3:0] issue_round_q;
  logic       issue_final_q;
  logic       err_q;

  logic [3:0] req;
  logic [3:0] gnt;
  logic [1:0] gnt_idx;
  logic       gnt_vld;
  logic       bad_start;
  logic       stray_ret;

  always_comb begin
    req       = '0;
    slot_busy = '0;
    slot_done = '0;
    for (int i = 0; i < NUM_CTX; i++) begin
      req[i]       = (st_q[i] == CTX_READY);
      slot_busy[i] = (st_q[i] != CTX_IDLE);
      slot_done[i] = (st_q[i] == CTX_DONE);
    end
  end

  rr_arb4 u_arb (
    .req_i     (req),
    .last_i    (last_grant_q),
    .gnt_o     (gnt),
    .gnt_idx_o (gnt_idx),
    .gnt_vld_o (gnt_vld)
  );

  always_comb begin
    bad_start = 1'b0;
    stray_ret = 1'b0;
    for (int i = 0; i < NUM_CTX; i++) begin
      st_d[i]    = st_q[i];
      round_d[i] = round_q[i];
      case (st_q[i])
        CTX_IDLE: if (slot_start[i]) begin
          st_d[i]    = CTX_READY;
          round_d[i] = 4'd1;
        end
        CTX_READY: if (gnt[i]) st_d[i] = CTX_INFLIGHT;
        CTX_DONE:  if (slot_ack[i]) st_d[i] = CTX_IDLE;
        default: ;
      endcase
      if (slot_start[i] && (st_q[i] != CTX_IDLE)) bad_start = 1'b1;
      // A return only counts against an in-flight context; anything else is a protocol error.
      if (dp_ret_vld && (dp_ret_pntr == 2'(i))) begin
        if (st_q[i] == CTX_INFLIGHT) begin
          if (round_q[i] == LAST_ROUND) begin
            st_d[i] = CTX_DONE;
          end else begin
            st_d[i]    = CTX_READY;
            round_d[i] = round_q[i] + 4'd1;
          end
        end else begin
          stray_ret = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_CTX; i++) begin
        st_q[i]    <= CTX_IDLE;
        round_q[i] <= '0;
      end
      last_grant_q  <= 2'd3;
      issue_vld_q   <= 1'b0;
      issue_pntr_q  <= '0;
      issue_round_q <= '0;
      issue_final_q <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_CTX; i++) begin
        st_q[i]    <= st_d[i];
        round_q[i] <= round_d[i];
      end
      if (gnt_vld) last_grant_q <= gnt_idx;
      issue_vld_q   <= gnt_vld;
      issue_pntr_q  <= gnt_vld ? gnt_idx : 2'd0;
      issue_round_q <= gnt_vld ? round_q[gnt_idx] : 4'd0;
      issue_final_q <= gnt_vld && (round_q[gnt_idx] == LAST_ROUND);
      err_q         <= err_q | bad_start | stray_ret;
    end
  end

  assign dp_issue_vld   = issue_vld_q;
  assign dp_pntr_num    = issue_pntr_q;
  assign dp_round       = issue_round_q;
  assign dp_final_round = issue_final_q;
  assign err_sticky     = err_q;

`ifdef AES_SCHED_DEBUG_EN
  logic [7:0]                rd_ret_cnt_q;
  logic [15:0]               issue_cnt_q;
  logic                      stray_q;
  logic                      bad_start_q;
  logic [CPU_DATA_WIDTH-1:0] rd_data_q;
  logic [31:0]               dbg_word;

  always_comb begin
    dbg_word                       = '0;
    dbg_word[DBG_RDCNT_LSB +: 8]   = rd_ret_cnt_q;
    dbg_word[DBG_LGNT_LSB +: 4]    = 4'b0001 << last_grant_q;
    dbg_word[DBG_ERR_LSB +: 4]     = {stray_q, bad_start_q, 2'b00};
    dbg_word[DBG_ISSUE_LSB +: 16]  = issue_cnt_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ret_cnt_q <= '0;
      issue_cnt_q  <= '0;
      stray_q      <= 1'b0;
      bad_start_q  <= 1'b0;
      rd_data_q    <= '0;
    end else begin
      if (cpu_rd && dp_ret_vld && (rd_ret_cnt_q != 8'hFF)) rd_ret_cnt_q <= rd_ret_cnt_q + 8'd1;
      if (issue_vld_q) issue_cnt_q <= issue_cnt_q + 16'd1;
      stray_q     <= stray_q | stray_ret;
      bad_start_q <= bad_start_q | bad_start;
      if (cpu_rd) rd_data_q <= CPU_DATA_WIDTH'(dbg_word);
    end
  end

  assign cpu_rd_data = rd_data_q;
`else
  logic unused_cpu_rd;
  assign unused_cpu_rd = cpu_rd;
  assign cpu_rd_data   = '0;
`endif

endmodule

// File: tb/tb_aes_round_sched.sv
// tb/tb_aes_round_sched.sv - scoreboard bench for aes_round_sched with directed vectors
module tb_aes_round_sched;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [3:0]  slot_start = '0;
  logic [3:0]  slot_ack = '0;
  logic [3:0]  slot_busy;
  logic [3:0]  slot_done;
  logic        dp_issue_vld;
  logic [1:0]  dp_pntr_num;
  logic [3:0]  dp_round;
  logic        dp_final_round;
  logic        dp_ret_vld;
  logic [1:0]  dp_ret_pntr;
  logic        cpu_rd = 1'b0;
  logic [31:0] cpu_rd_data;
  logic        err_sticky;

  logic        ag_ret_vld = 1'b0;
  logic [1:0]  ag_ret_pntr = '0;
  logic        man_ret_vld = 1'b0;
  logic [1:0]  man_ret_pntr = '0;
  logic        auto_ret = 1'b0;
  int          ret_delay = 0;
  int          cyc = 0;

  logic [6:0]  exp_q [$];
  logic [6:0]  mon_exp;
  logic [1:0]  pend_p [$];
  int          pend_due [$];

  int          n_checks = 0;
  int          n_fail = 0;

  assign dp_ret_vld  = ag_ret_vld | man_ret_vld;
  assign dp_ret_pntr = man_ret_vld ? man_ret_pntr : ag_ret_pntr;

  aes_round_sched dut (
    .clk            (clk),
    .reset          (rst_n),
    .slot_start     (slot_start),
    .slot_ack       (slot_ack),
    .slot_busy      (slot_busy),
    .slot_done      (slot_done),
    .dp_issue_vld   (dp_issue_vld),
    .dp_pntr_num    (dp_pntr_num),
    .dp_round       (dp_round),
    .dp_final_round (dp_final_round),
    .dp_ret_vld     (dp_ret_vld),
    .dp_ret_pntr    (dp_ret_pntr),
    .cpu_rd         (cpu_rd),
    .cpu_rd_data    (cpu_rd_data),
    .err_sticky     (err_sticky)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic push_exp(input int c, input int r);
    exp_q.push_back({2'(c), 4'(r), (r == 10)});
  endtask

  // Monitor: every issue pops one expected {pntr, round, final}
  always @(negedge clk) begin
    if (rst_n && dp_issue_vld) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_issue: got pntr=%0d round=%0d, required no issue", dp_pntr_num, dp_round);
      end else begin
        mon_exp = exp_q.pop_front();
        check("issue", 64'({dp_pntr_num, dp_round, dp_final_round}), 64'(mon_exp));
      end
    end
  end

  // Datapath model: returns each issued round ret_delay cycles later
  always @(negedge clk) begin
    ag_ret_vld = 1'b0;
    if (auto_ret && rst_n) begin
      if (dp_issue_vld) begin
        pend_p.push_back(dp_pntr_num);
        pend_due.push_back(cyc + ret_delay);
      end
      if (pend_due.size() != 0 && pend_due[0] <= cyc) begin
        ag_ret_vld  = 1'b1;
        ag_ret_pntr = pend_p.pop_front();
        void'(pend_due.pop_front());
      end
    end
  end

  task automatic do_reset();
    auto_ret    = 1'b0;
    man_ret_vld = 1'b0;
    slot_start  = '0;
    slot_ack    = '0;
    cpu_rd      = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check("reset_outputs", 64'({slot_busy, slot_done, dp_issue_vld, dp_pntr_num, dp_round,
                                     dp_final_round, err_sticky}), 64'(0));
    check("reset_rd_data", 64'(cpu_rd_data), 64'(0));
    exp_q.delete();
    pend_p.delete();
    pend_due.delete();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic pulse_start(input logic [3:0] m);
    slot_start = m;
    @(negedge clk);
    slot_start = '0;
  endtask

  task automatic pulse_ack(input logic [3:0] m);
    slot_ack = m;
    @(negedge clk);
    slot_ack = '0;
  endtask

  task automatic pulse_ret(input logic [1:0] p);
    man_ret_vld  = 1'b1;
    man_ret_pntr = p;
    @(negedge clk);
    man_ret_vld  = 1'b0;
  endtask

  task automatic pulse_rd();
    cpu_rd = 1'b1;
    @(negedge clk);
    cpu_rd = 1'b0;
  endtask

  task automatic wait_done(input logic [3:0] mask, input int limit, input string name);
    int n = 0;
    while (((slot_done & mask) != mask) && n < limit) begin
      @(negedge clk);
      n++;
    end
    check(name, 64'(slot_done & mask), 64'(mask));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, required test completion");
    $fatal(1, "watchdog");
  end

  int  w;
  bit  found;

  initial begin
    do_reset();

    // Single context, datapath latency 4
    for (int r = 1; r <= 10; r++) push_exp(0, r);
    ret_delay = 4;
    auto_ret  = 1'b1;
    pulse_start(4'b0001);
    wait_done(4'b0001, 200, "t1_done");
    check("t1_busy_while_done", 64'(slot_busy), 64'(4'b0001));
    repeat (3) @(negedge clk);
    check("t1_done_level", 64'(slot_done), 64'(4'b0001));
    pulse_ack(4'b0001);
    check("t1_busy_after_ack", 64'(slot_busy), 64'(0));
    check("t1_done_after_ack", 64'(slot_done), 64'(0));
    check("t1_sb_empty", 64'(exp_q.size()), 64'(0));

    // All four started together, immediate returns
    do_reset();
    for (int r = 1; r <= 10; r++)
      for (int c = 0; c < 4; c++) push_exp(c, r);
    ret_delay = 0;
    auto_ret  = 1'b1;
    pulse_start(4'b1111);
    wait_done(4'b1111, 400, "t2_done");
    pulse_ack(4'b1111);
    check("t2_busy_after_ack", 64'(slot_busy), 64'(0));
    check("t2_sb_empty", 64'(exp_q.size()), 64'(0));
    check("t2_no_err", 64'(err_sticky), 64'(0));
`ifndef AES_SCHED_DEBUG_EN
    pulse_rd();
    @(negedge clk);
    check("nodbg_rd_data", 64'(cpu_rd_data), 64'(0));
`endif

    // Start on an in-flight context
    do_reset();
    push_exp(2, 1);
    pulse_start(4'b0100);
    @(negedge clk);
    check("t3_inflight_busy", 64'(slot_busy), 64'(4'b0100));
    pulse_start(4'b0100);
    check("t3_err_bad_start", 64'(err_sticky), 64'(1));
    push_exp(2, 2);
    pulse_ret(2'd2);
    repeat (3) @(negedge clk);
    check("t3_sb_empty", 64'(exp_q.size()), 64'(0));

    // Stray return on an idle context
    do_reset();
    check("t4_err_clear", 64'(err_sticky), 64'(0));
    pulse_ret(2'd1);
    check("t4_err_stray", 64'(err_sticky), 64'(1));
    check("t4_state", 64'({slot_busy, slot_done}), 64'(0));

    // Reset in the middle of round 5
    do_reset();
    for (int r = 1; r <= 10; r++) begin
      push_exp(0, r);
      push_exp(3, r);
    end
    ret_delay = 4;
    auto_ret  = 1'b1;
    pulse_start(4'b1001);
    found = 1'b0;
    w = 0;
    while (!found && w < 300) begin
      @(negedge clk);
      w++;
      if (dp_issue_vld && dp_pntr_num == 2'd0 && dp_round == 4'd5) found = 1'b1;
    end
    check("t5_round5_seen", 64'(found), 64'(1));
    do_reset();
    check("t5_err_after_reset", 64'(err_sticky), 64'(0));
    pulse_ret(2'd3);
    check("t5_late_ret_err", 64'(err_sticky), 64'(1));
    for (int r = 1; r <= 10; r++) push_exp(0, r);
    ret_delay = 0;
    auto_ret  = 1'b1;
    pulse_start(4'b0001);
    wait_done(4'b0001, 200, "t5_restart_done");
    check("t5_only_ctx0", 64'(slot_busy), 64'(4'b0001));
    pulse_ack(4'b0001);
    check("t5_sb_empty", 64'(exp_q.size()), 64'(0));

`ifdef AES_SCHED_DEBUG_EN
    // Debug register: reads coincident with returns, issue count, error sources
    do_reset();
    for (int r = 1; r <= 4; r++) push_exp(0, r);
    pulse_start(4'b0001);
    for (int k = 0; k < 3; k++) begin
      w = 0;
      while (!dp_issue_vld && w < 20) begin
        @(negedge clk);
        w++;
      end
      check("t6_issue_seen", 64'(dp_issue_vld), 64'(1));
      man_ret_vld  = 1'b1;
      man_ret_pntr = 2'd0;
      cpu_rd       = 1'b1;
      @(negedge clk);
      man_ret_vld  = 1'b0;
      cpu_rd       = 1'b0;
    end
    repeat (5) @(negedge clk);
    pulse_rd();
    check("t6_dbg_word", 64'(cpu_rd_data), 64'(32'h0004_0103));
    repeat (3) @(negedge clk);
    check("t6_dbg_held", 64'(cpu_rd_data), 64'(32'h0004_0103));
    pulse_start(4'b0001);
    pulse_ret(2'd1);
    pulse_rd();
    check("t6_dbg_err_src", 64'(cpu_rd_data), 64'(32'h0004_C103));
    check("t6_sb_empty", 64'(exp_q.size()), 64'(0));
`endif

    auto_ret = 1'b0;
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
